// File: rtl/felis_exec_pkg.sv
// Shared definitions for the execution-unit sequencer: unit indices,
// unit count and the sequencer state encoding.
package felis_exec_pkg;

  typedef enum logic [1:0] {
    UNIT_ALU     = 2'd0,
    UNIT_FPU_ALU = 2'd1,
    UNIT_FPU_MUL = 2'd2,
    UNIT_MEM     = 2'd3
  } unit_e;

  localparam int NUM_EXEC_UNITS = 4;

  // Every unit held in reset
  localparam logic [NUM_EXEC_UNITS-1:0] ALL_HELD = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    WB   = 2'd2
  } state_e;

endpackage

// File: rtl/exec_unit_sequencer.sv
// Issues one decoded op at a time to an execution unit, waits for completion
// or timeout, then presents the result on a valid/ready writeback port.
module exec_unit_sequencer
  import felis_exec_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   in_unit,
  input  logic [4:0]   in_dest,
  input  logic         in_dest_fp,
  output logic [3:0]   unit_reset,
  input  logic [3:0]   unit_completed,
  input  logic [127:0] unit_out,
  output logic         wb_valid,
  input  logic         wb_ready,
  output logic [31:0]  wb_data,
  output logic [4:0]   wb_dest,
  output logic         wb_dest_fp,
  output logic         wb_err,
  output logic         timeout_err,
  output logic [15:0]  ops_done
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_r, state_s;
  logic [1:0]  sel_r, sel_s;
  logic [7:0]  tmo_cnt_r, tmo_cnt_s;
  logic [3:0]  unit_reset_s;
  logic        wb_valid_s;
  logic [31:0] wb_data_s;
  logic [4:0]  wb_dest_s;
  logic        wb_dest_fp_s;
  logic        wb_err_s;
  logic        timeout_err_s;
  logic [15:0] ops_done_s;
  logic [31:0] sel_out_s;

  // Acceptance depends on state alone so the upstream never sees a bypass path
  assign in_ready = (state_r == IDLE);

  // Result lane of the selected unit
  assign sel_out_s = unit_out[{sel_r, 5'd0} +: 32];

  // Next-state and next-output logic
  always_comb begin
    state_s       = state_r;
    sel_s         = sel_r;
    tmo_cnt_s     = tmo_cnt_r;
    unit_reset_s  = unit_reset;
    wb_valid_s    = wb_valid;
    wb_data_s     = wb_data;
    wb_dest_s     = wb_dest;
    wb_dest_fp_s  = wb_dest_fp;
    wb_err_s      = wb_err;
    timeout_err_s = timeout_err;
    ops_done_s    = ops_done;

    case (state_r)
      IDLE: begin
        if (in_valid) begin
          sel_s        = in_unit;
          wb_dest_s    = in_dest;
          wb_dest_fp_s = in_dest_fp;
          tmo_cnt_s    = 8'd0;
          unit_reset_s = ALL_HELD & ~(4'b0001 << in_unit);
          state_s      = WAIT;
        end else begin
          unit_reset_s = ALL_HELD;
        end
      end
      WAIT: begin
        // Completion wins over a timeout landing in the same cycle
        if (unit_completed[sel_r]) begin
          wb_data_s    = sel_out_s;
          wb_err_s     = 1'b0;
          unit_reset_s = ALL_HELD;
          wb_valid_s   = 1'b1;
          state_s      = WB;
        end else if (tmo_cnt_r == TMO_LAST) begin
          wb_data_s     = 32'd0;
          wb_err_s      = 1'b1;
          unit_reset_s  = ALL_HELD;
          timeout_err_s = 1'b1;
          wb_valid_s    = 1'b1;
          state_s       = WB;
        end else begin
          tmo_cnt_s = tmo_cnt_r + 8'd1;
        end
      end
      WB: begin
        if (wb_ready) begin
          wb_valid_s = 1'b0;
          ops_done_s = ops_done + 16'd1;
          state_s    = IDLE;
        end else begin
          wb_valid_s = 1'b1;
        end
      end
      default: begin
        state_s      = IDLE;
        unit_reset_s = ALL_HELD;
        wb_valid_s   = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      sel_r       <= 2'd0;
      tmo_cnt_r   <= 8'd0;
      unit_reset  <= ALL_HELD;
      wb_valid    <= 1'b0;
      wb_data     <= 32'd0;
      wb_dest     <= 5'd0;
      wb_dest_fp  <= 1'b0;
      wb_err      <= 1'b0;
      timeout_err <= 1'b0;
      ops_done    <= 16'd0;
    end else begin
      state_r     <= state_s;
      sel_r       <= sel_s;
      tmo_cnt_r   <= tmo_cnt_s;
      unit_reset  <= unit_reset_s;
      wb_valid    <= wb_valid_s;
      wb_data     <= wb_data_s;
      wb_dest     <= wb_dest_s;
      wb_dest_fp  <= wb_dest_fp_s;
      wb_err      <= wb_err_s;
      timeout_err <= timeout_err_s;
      ops_done    <= ops_done_s;
    end
  end

endmodule

// File: tb/tb_exec_unit_sequencer.sv
// Self-checking bench: each op's outcome (latency, payload, error) is derived
// from the op's completion delay and the timeout limit, cycle by cycle.
module tb_exec_unit_sequencer;

  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_unit;
  logic [4:0]   in_dest;
  logic         in_dest_fp;
  logic [3:0]   unit_reset;
  logic [3:0]   unit_completed;
  logic [127:0] unit_out;
  logic         wb_valid;
  logic         wb_ready;
  logic [31:0]  wb_data;
  logic [4:0]   wb_dest;
  logic         wb_dest_fp;
  logic         wb_err;
  logic         timeout_err;
  logic [15:0]  ops_done;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] m_ops = 16'd0;
  logic        m_terr = 1'b0;

  exec_unit_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_unit(in_unit),
    .in_dest(in_dest), .in_dest_fp(in_dest_fp),
    .unit_reset(unit_reset), .unit_completed(unit_completed), .unit_out(unit_out),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .wb_dest(wb_dest), .wb_dest_fp(wb_dest_fp), .wb_err(wb_err),
    .timeout_err(timeout_err), .ops_done(ops_done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Random result on every lane, fixed value on the lane under test
  task automatic drive_out(input int unit, input logic [31:0] data);
    unit_out = {$urandom, $urandom, $urandom, $urandom};
    unit_out[unit*32 +: 32] = data;
  endtask

  // One op: completion n cycles after release (n >= TO means never in time),
  // writeback stalled wbd cycles, noise 0=none 1=random 2=all other units.
  task automatic run_op(input int unit, input logic [4:0] dest, input logic fp,
                        input int n, input int wbd, input int noise,
                        input logic [31:0] data);
    bit         err;
    int         lat;
    logic [3:0] rel;
    logic [3:0] comp;
    err = (n > TO - 1);
    lat = err ? TO + 1 : n + 2;
    rel = 4'hF & ~(4'b0001 << unit);

    @(negedge clk);
    check_val("idle_in_ready", 32'(in_ready), 32'd1);
    check_val("idle_unit_reset", 32'(unit_reset), 32'hF);
    check_val("idle_wb_valid", 32'(wb_valid), 32'd0);
    check_val("idle_ops_done", 32'(ops_done), 32'(m_ops));
    in_valid = 1'b1;
    in_unit = 2'(unit);
    in_dest = dest;
    in_dest_fp = fp;
    drive_out(unit, data);

    for (int c = 1; c <= lat + wbd + 1; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_unit = 2'($urandom);
      in_dest = 5'($urandom);
      in_dest_fp = 1'($urandom);
      if (c < lat) begin
        check_val("wait_in_ready", 32'(in_ready), 32'd0);
        check_val("wait_wb_valid", 32'(wb_valid), 32'd0);
        check_val("wait_unit_reset", 32'(unit_reset), 32'(rel));
        comp = (noise == 2) ? 4'hF : (noise == 1) ? 4'($urandom) : 4'h0;
        comp[unit] = (c >= n + 1);
        unit_completed = comp;
        drive_out(unit, data);
      end else if (c < lat + wbd + 1) begin
        if (err) m_terr = 1'b1;
        check_val("wb_valid", 32'(wb_valid), 32'd1);
        check_val("wb_data", wb_data, err ? 32'd0 : data);
        check_val("wb_dest", 32'(wb_dest), 32'(dest));
        check_val("wb_dest_fp", 32'(wb_dest_fp), 32'(fp));
        check_val("wb_err", 32'(wb_err), 32'(err));
        check_val("wb_in_ready", 32'(in_ready), 32'd0);
        check_val("wb_unit_reset", 32'(unit_reset), 32'hF);
        check_val("timeout_err", 32'(timeout_err), 32'(m_terr));
        unit_completed = 4'($urandom);
        unit_out = {$urandom, $urandom, $urandom, $urandom};
        wb_ready = (c == lat + wbd);
      end else begin
        m_ops = m_ops + 16'd1;
        wb_ready = 1'b0;
        unit_completed = 4'h0;
        check_val("post_wb_valid", 32'(wb_valid), 32'd0);
        check_val("post_ops_done", 32'(ops_done), 32'(m_ops));
        check_val("post_in_ready", 32'(in_ready), 32'd1);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    in_unit = 2'd0;
    in_dest = 5'd0;
    in_dest_fp = 1'b0;
    unit_completed = 4'h0;
    unit_out = 128'd0;
    wb_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_in_ready", 32'(in_ready), 32'd1);
    check_val("rst_unit_reset", 32'(unit_reset), 32'hF);
    check_val("rst_wb_valid", 32'(wb_valid), 32'd0);
    check_val("rst_wb_data", wb_data, 32'd0);
    check_val("rst_wb_dest", 32'({wb_dest_fp, wb_dest}), 32'd0);
    check_val("rst_wb_err", 32'(wb_err), 32'd0);
    check_val("rst_timeout_err", 32'(timeout_err), 32'd0);
    check_val("rst_ops_done", 32'(ops_done), 32'd0);
    reset = 1'b0;

    // Reset while waiting on unit 3 abandons the op
    @(negedge clk);
    in_valid = 1'b1;
    in_unit = 2'd3;
    in_dest = 5'd9;
    @(negedge clk);
    in_valid = 1'b0;
    check_val("rw_unit_reset", 32'(unit_reset), 32'h7);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_val("rw_in_ready", 32'(in_ready), 32'd1);
    check_val("rw_unit_reset_after", 32'(unit_reset), 32'hF);
    check_val("rw_wb_valid", 32'(wb_valid), 32'd0);
    check_val("rw_ops_done", 32'(ops_done), 32'd0);

    run_op(1, 5'd7, 1'b1, 1, 0, 0, 32'h3F80_0000);
    run_op(2, 5'd12, 1'b0, 255, 0, 0, 32'h1234_5678);
    run_op(3, 5'd3, 1'b0, 2, 5, 1, 32'hCAFE_F00D);
    run_op(0, 5'd31, 1'b0, 3, 1, 2, 32'hDEAD_BEEF);
    run_op(1, 5'd1, 1'b1, TO - 1, 0, 1, 32'hA5A5_5A5A);
    run_op(0, 5'd2, 1'b0, TO, 0, 1, 32'h0BAD_0BAD);
    run_op(2, 5'd4, 1'b1, 0, 2, 2, 32'h7777_1111);

    for (int i = 0; i < 40; i++) begin
      run_op(int'($urandom_range(0, 3)), 5'($urandom), 1'($urandom),
             int'($urandom_range(0, 10)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 2)), $urandom);
    end

    // Counter wrap: preload the completed-op count to its maximum
    @(negedge clk);
    force dut.ops_done = 16'hFFFF;
    #1;
    release dut.ops_done;
    m_ops = 16'hFFFF;
    run_op(3, 5'd5, 1'b0, 1, 0, 0, 32'h0000_0001);
    check_val("wrap_ops_done", 32'(ops_done), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/exec_unit_sequencer.md
EXEC_UNIT_SEQUENCER -- requirements
Module: exec_unit_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, meaning max WAIT cycles before an operation is abandoned (legal 2..255).
REQ-002 SHALL have clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have in_valid  input  1  decoded op offered.
REQ-005 SHALL have in_ready  output  1  sequencer can accept an op.
REQ-006 SHALL have in_unit  input  2  target exec unit index.
REQ-007 SHALL have in_dest  input  5  destination register number.
REQ-008 SHALL have in_dest_fp  input  1  destination is FP register file.
REQ-009 SHALL have unit_reset  output  4  per-unit hold/start; 1 = unit held in reset, 0 = unit runs.
REQ-010 SHALL have unit_completed  input  4  per-unit completion flag.
REQ-011 SHALL have unit_out  input  128  unit i result at bits [32i+31:32i].
REQ-012 SHALL have wb_valid, wb_ready  output/input  1/1  writeback handshake.
REQ-013 SHALL have wb_data  output  32, wb_dest  output  5, wb_dest_fp  output  1, wb_err  output  1  writeback payload.
REQ-014 SHALL have timeout_err  output  1  sticky timeout indicator.
REQ-015 SHALL have ops_done  output  16  count of completed writebacks.

Function
REQ-016 SHALL implement states IDLE, WAIT, WB.
REQ-017 SHALL drive in_ready = 1 only in IDLE (combinational from state).
REQ-018 SHALL, in IDLE with in_valid, latch in_unit/in_dest/in_dest_fp, clear the timeout counter, drive unit_reset[in_unit] to 0 (registered), and go to WAIT.
REQ-019 SHALL keep all non-selected unit_reset bits at 1 at all times.
REQ-020 SHALL, in WAIT, sample only unit_completed[sel]; completion from other units is ignored.
REQ-021 SHALL, on unit_completed[sel] = 1 in WAIT, register unit_out[sel] into wb_data, set wb_err = 0, set unit_reset[sel] to 1, and go to WB.
REQ-022 SHALL, in WAIT without completion, increment the 8-bit timeout counter; when counter = TIMEOUT_CYCLES-1, go to WB with wb_data = 0, wb_err = 1, unit_reset[sel] = 1, timeout_err = 1.
REQ-023 SHALL give completion priority over timeout when both occur in the same cycle.
REQ-024 SHALL assert wb_valid only in WB and hold wb_data/wb_dest/wb_dest_fp/wb_err stable until wb_ready.
REQ-025 SHALL, in WB with wb_ready, increment ops_done (wrapping 0xFFFF to 0x0000, counted for errored ops too) and go to IDLE.
REQ-026 SHALL give latency: accept in cycle T, one-cycle unit -> wb_valid = 1 in cycle T+3; N-cycle unit -> T+2+N.
REQ-027 SHALL not accept a new op in the cycle WB exits (no bypass); next accept earliest the following cycle.

Reset
REQ-028 SHALL on reset: state IDLE, unit_reset = 4'b1111, wb_valid = 0, wb_data = 0, wb_dest = 0, wb_dest_fp = 0, wb_err = 0, timeout_err = 0, ops_done = 0, timeout counter 0.
REQ-029 SHALL on reset during WAIT or WB abandon the op with no writeback and no ops_done increment.
REQ-030 SHALL clear timeout_err only by reset.

Structure
REQ-031 SHALL place unit index enum (UNIT_ALU=0, UNIT_FPU_ALU=1, UNIT_FPU_MUL=2, UNIT_MEM=3), NUM_EXEC_UNITS = 4 and the state enum in shared package felis_exec_pkg.
REQ-032 SHALL be a single module with no sub-modules; timeout counter and unit mux inline.

Verification
REQ-033 SHALL test: accept in_unit=1, in_dest=7, dest_fp=1; unit 1 completes one cycle after release with out=0x3F800000 -> wb_valid at T+3, wb_data=0x3F800000, wb_dest=7, wb_dest_fp=1, wb_err=0, ops_done=1.
REQ-034 SHALL test: unit 2 never completes, TIMEOUT_CYCLES=8 -> WB after 8 WAIT cycles, wb_data=0, wb_err=1, timeout_err=1, unit_reset=4'b1111.
REQ-035 SHALL test: wb_ready held 0 for 5 cycles -> wb_valid and payload stable, in_ready=0 throughout, unit_reset[sel]=1.
REQ-036 SHALL test: selected unit 0 while unit_completed[3]=1 asserted -> no transition; unit 0 completion with 0xDEADBEEF -> wb_data=0xDEADBEEF.
REQ-037 SHALL test: reset asserted in WAIT -> next cycle IDLE, unit_reset=4'b1111, wb_valid=0, ops_done unchanged at 0.
REQ-038 SHALL test: preload ops_done to 0xFFFF via 65535 ops (or force) then one op -> ops_done=0x0000.
